sprite_motion_ctrl: RTL

//   Per-sprite position generator for the VGA game engine. Produces the X/Y top-left

---
 rtl/sprite_motion_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/sprite_motion_ctrl.sv
// rtl/sprite_motion_ctrl.sv - sprite X/Y generator: autonomous bounce or key steering, clamped at screen edges
module sprite_motion_ctrl #(
   parameter int POS_W     = 10,
   parameter int SCREEN_W  = 640,
   parameter int SCREEN_H  = 480,
   parameter int SPRITE_W  = 388,
   parameter int SPRITE_H  = 68,
   parameter int SPEED_X   = 1,
   parameter int SPEED_Y   = 1,
   parameter int INIT_X    = 0,
   parameter int INIT_Y    = 0,
   parameter int INIT_XDIR = 1,
   parameter int INIT_YDIR = 1
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic             TICK,
   input  logic [1:0]       MODE,
   input  logic [3:0]       wasd,
   input  logic [3:0]       arrows,
   output logic [POS_W-1:0] POS_X,
   output logic [POS_W-1:0] POS_Y,
   output logic             HIT_X,
   output logic             HIT_Y
);

   localparam logic [POS_W:0] maxX = (POS_W+1)'(SCREEN_W - SPRITE_W);
   localparam logic [POS_W:0] maxY = (POS_W+1)'(SCREEN_H - SPRITE_H);
   localparam logic [POS_W:0] spdX = (POS_W+1)'(SPEED_X);
   localparam logic [POS_W:0] spdY = (POS_W+1)'(SPEED_Y);
   localparam logic [POS_W-1:0] initX = POS_W'(INIT_X);
   localparam logic [POS_W-1:0] initY = POS_W'(INIT_Y);
   localparam logic initXDir = (INIT_XDIR != 0);
   localparam logic initYDir = (INIT_YDIR != 0);

   typedef enum logic [1:0] {
      MODE_BOUNCE = 2'd0,
      MODE_WASD   = 2'd1,
      MODE_ARROWS = 2'd2,
      MODE_FREEZE = 2'd3
   } modeT;

   typedef struct packed {
      logic             clamp;
      logic [POS_W-1:0] pos;
   } stepT;

   // One step along an axis in POS_W+1 bits so the sum can never wrap.
   function automatic stepT stepAxis(
      input logic [POS_W-1:0] pos,
      input logic             plus,
      input logic [POS_W:0]   speed,
      input logic [POS_W:0]   limit
   );
      logic [POS_W:0] wide;
      logic [POS_W:0] sum;
      stepT r;
      wide    = {1'b0, pos};
      sum     = wide + speed;
      r.clamp = 1'b0;
      r.pos   = pos;
      if (plus) begin
         if (sum >= limit) begin
            r.clamp = 1'b1;
            r.pos   = limit[POS_W-1:0];
         end else begin
            r.pos = sum[POS_W-1:0];
         end
      end else begin
         if (wide <= speed) begin
            r.clamp = 1'b1;
            r.pos   = '0;
         end else begin
            r.pos = pos - speed[POS_W-1:0];
         end
      end
      return r;
   endfunction

   logic [POS_W-1:0] posX, posY, nxtPosX, nxtPosY;
   logic             dirX, dirY, nxtDirX, nxtDirY;
   logic             hitX, hitY, nxtHitX, nxtHitY;
   logic             moveX, moveY, plusX, plusY;
   logic [3:0]       keys;
   modeT             mode;
   stepT             stepX, stepY;

   assign mode = modeT'(MODE);

   always_comb begin
      nxtPosX = posX;
      nxtPosY = posY;
      nxtDirX = dirX;
      nxtDirY = dirY;
      nxtHitX = 1'b0;
      nxtHitY = 1'b0;
      moveX   = 1'b0;
      moveY   = 1'b0;
      plusX   = dirX;
      plusY   = dirY;
      keys    = (mode == MODE_ARROWS) ? arrows : wasd;

      case (mode)
         MODE_BOUNCE: begin
            moveX = 1'b1;
            moveY = 1'b1;
         end
         MODE_WASD, MODE_ARROWS: begin
            // Opposing keys cancel; +X is right, +Y is down.
            moveX = keys[0] ^ keys[2];
            plusX = keys[0];
            moveY = keys[1] ^ keys[3];
            plusY = keys[1];
         end
         default: begin
         end
      endcase

      stepX = stepAxis(posX, plusX, spdX, maxX);
      stepY = stepAxis(posY, plusY, spdY, maxY);

      if (TICK && moveX) begin
         nxtPosX = stepX.pos;
         nxtHitX = stepX.clamp;
         if (mode == MODE_BOUNCE && stepX.clamp) nxtDirX = ~dirX;
      end
      if (TICK && moveY) begin
         nxtPosY = stepY.pos;
         nxtHitY = stepY.clamp;
         if (mode == MODE_BOUNCE && stepY.clamp) nxtDirY = ~dirY;
      end
   end

   always_ff @(negedge CLOCK) begin
      if (RESET) begin
         posX <= initX;
         posY <= initY;
         dirX <= initXDir;
         dirY <= initYDir;
         hitX <= 1'b0;
         hitY <= 1'b0;
      end else begin
         posX <= nxtPosX;
         posY <= nxtPosY;
         dirX <= nxtDirX;
         dirY <= nxtDirY;
         hitX <= nxtHitX;
         hitY <= nxtHitY;
      end
   end

   assign POS_X = posX;
   assign POS_Y = posY;
   assign HIT_X = hitX;
   assign HIT_Y = hitY;

endmodule
